// File: rtl/m_illegaltrap_pkg.sv
// Shared constants and types for the illegal-instruction trap block.
// Covers the RV32I opcode map, the funct7 values that decode cares about, and the FSM state type.
package m_illegaltrap_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  function automatic logic opcode_known(input logic [6:0] opc);
    logic known;
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
      default:                                            known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/m_illegaldecode.sv
// Combinational legality check of one instruction word.
// The decode depth is chosen by LAZY_DECODE: 0 is full, 1 is opcode only, 2 is INSTR[0] only.
module m_illegaldecode
  import m_illegaltrap_pkg::*;
#(
  parameter int LAZY_DECODE = 0,
  parameter int MULDIV      = 1
) (
  input  logic [31:0] INSTR,
  input  logic        corerunning,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       full_bad;
  logic       bad;

  assign opc = INSTR[6:0];
  assign f3  = INSTR[14:12];
  assign f7  = INSTR[31:25];
  assign rd  = INSTR[11:7];
  assign rs1 = INSTR[19:15];

  // rs2/shamt never affects legality
  logic unused_rs2;
  assign unused_rs2 = ^INSTR[24:20];

  always_comb begin
    full_bad = 1'b0;
    if (!opcode_known(opc)) begin
      full_bad = 1'b1;
    end else begin
      case (opc)
        OPC_OP_IMM: begin
          if (f3 == F3_SLL)
            full_bad = (f7 != F7_BASE);
          else if (f3 == F3_SR)
            full_bad = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
        OPC_OP: begin
          if (f7 == F7_BASE)
            full_bad = 1'b0;
          else if (f7 == F7_ALT)
            full_bad = (f3 != F3_ADDSUB) && (f3 != F3_SR);
          else if (f7 == F7_MULDIV)
            full_bad = (MULDIV == 0);
          else
            full_bad = 1'b1;
        end
        // ecall/ebreak space: operand fields must be zero
        OPC_SYSTEM: begin
          if (f3[1:0] == 2'b00)
            full_bad = (rs1 != 5'd0) || (rd != 5'd0);
        end
        default: full_bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    bad = full_bad;
    if (LAZY_DECODE == 2)
      bad = ~INSTR[0];
    else if (LAZY_DECODE == 1)
      bad = ~opcode_known(opc);
  end

  assign illegal = corerunning & bad;

endmodule

// File: rtl/m_illegaltrap.sv
// Illegal-instruction trap controller: verdict registers, trap FSM, faulting-word capture.
// Build option MIDGETV_ILLCNT_EN adds a saturating counter of trap entries on ill_cnt.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | accepting instructions, instr_ready=1
// ST_TRAP | illegal word captured in mtval, trap_req=1 until trap_ack
module m_illegaltrap
  import m_illegaltrap_pkg::*;
#(
  parameter int LAZY_DECODE = 0,
  parameter int MULDIV      = 1,
  parameter int CNTW        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            corerunning,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     INSTR,
  output logic            res_valid,
  output logic            res_legal,
  output logic            trap_req,
  input  logic            trap_ack,
  output logic [31:0]     mtval,
  output logic [CNTW-1:0] ill_cnt,
  input  logic            cnt_clr
);

  state_t state_q;
  state_t state_d;
  logic   illegal;
  logic   accept;
  logic   trap_entry;

  m_illegaldecode #(
    .LAZY_DECODE (LAZY_DECODE),
    .MULDIV      (MULDIV)
  ) u_decode (
    .INSTR       (INSTR),
    .corerunning (corerunning),
    .illegal     (illegal)
  );

  assign accept     = instr_valid & instr_ready;
  assign trap_entry = accept & illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      res_valid <= 1'b0;
      res_legal <= 1'b0;
      mtval     <= 32'd0;
    end else begin
      state_q   <= state_d;
      res_valid <= accept;
      res_legal <= accept & ~illegal;
      if (trap_entry)
        mtval <= INSTR;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    trap_req    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && illegal)
          state_d = ST_TRAP;
      end
      // ready stays low through the ack cycle; acceptance resumes one cycle later
      ST_TRAP: begin
        trap_req = 1'b1;
        if (trap_ack)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MIDGETV_ILLCNT_EN
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  logic [CNTW-1:0] cnt_q;

  // clear wins over a coincident trap entry
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (cnt_clr)
      cnt_q <= '0;
    else if (trap_entry && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_ONE;
  end

  assign ill_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ill_cnt        = '0;
`endif

endmodule

// File: doc/m_illegaltrap.md
M_ILLEGALTRAP -- requirements
Module: m_illegaltrap

Interface
REQ-001 Parameter LAZY_DECODE, default 0; 0 = full decode (opcode, funct7, rs1/rd), 1 = opcode-only decode, 2 = INSTR[0]-only decode.
REQ-002 Parameter MULDIV, default 1; 1 = RV32M encodings legal, 0 = RV32M encodings illegal.
REQ-003 Parameter CNTW, default 8; width of the illegal-event counter, range 1..32.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 corerunning  in  1  core is executing; when 0, no instruction is ever flagged illegal.
REQ-007 instr_valid  in  1  INSTR is presented for checking.
REQ-008 instr_ready  out  1  block can accept an instruction this cycle.
REQ-009 INSTR  in  32  instruction word.
REQ-010 res_valid  out  1  one-cycle pulse; the verdict for the last accepted instruction is available.
REQ-011 res_legal  out  1  verdict; valid only while res_valid=1.
REQ-012 trap_req  out  1  illegal-instruction trap pending.
REQ-013 trap_ack  in  1  core has taken the trap.
REQ-014 mtval  out  32  offending instruction word.
REQ-015 ill_cnt  out  CNTW  saturating count of illegal instructions.
REQ-016 cnt_clr  in  1  clears ill_cnt.

Function
REQ-017 An instruction is accepted on any cycle where instr_valid=1 and instr_ready=1.
REQ-018 Decode is combinational on the accepted INSTR; res_valid and res_legal are registered and appear exactly 1 cycle after acceptance.
REQ-019 Full decode: legal opcodes (INSTR[6:0]) are 0000011, 0001111, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1100111, 1101111, 1110011; every other opcode is illegal.
REQ-020 Full decode, funct7 for OP-IMM shifts and OP: must be 0000000; 0100000 is also legal only for srai, sub and sra.
REQ-021 Full decode, MULDIV=1: funct7=0000001 is additionally legal for opcode 0110011 only, with any funct3.
REQ-022 Full decode, SYSTEM: opcode 1110011 with funct3[1:0]=00 is illegal if rs1!=0 or rd!=0.
REQ-023 State machine states: IDLE (instr_ready=1) and TRAP (instr_ready=0, trap_req=1).
REQ-024 IDLE to TRAP: on the cycle after accepting an illegal instruction while corerunning=1; mtval captures that INSTR in the same edge.
REQ-025 TRAP to IDLE: on trap_ack=1; instr_ready returns 1 in the following cycle, so no instruction is accepted in the ack cycle.
REQ-026 trap_ack in IDLE has no effect; mtval holds its value until the next illegal acceptance.
REQ-027 Legal instruction: res_valid=1 and res_legal=1, state stays IDLE, back-to-back acceptance allowed every cycle.
REQ-028 corerunning=0 at acceptance: res_legal=1, no trap, no count.

Reset
REQ-029 rst_n=0 at a clock edge forces state IDLE, res_valid=0, res_legal=0, trap_req=0, mtval=0, ill_cnt=0.
REQ-030 Reset mid-TRAP abandons the pending trap with no ack required; the first instruction is accepted on the first cycle after reset release.

Configuration
REQ-031 Macro MIDGETV_ILLCNT_EN: when defined, ill_cnt increments by 1 on each TRAP entry and saturates at all ones; cnt_clr takes priority over a simultaneous increment.
REQ-032 Without MIDGETV_ILLCNT_EN, ill_cnt is tied to 0, cnt_clr is ignored, and no counter flops are generated.

Structure
REQ-033 A shared package holds the opcode constants, the funct7 constants (0000000, 0100000, 0000001) and the state encoding type.
REQ-034 Combinational decode lives in sub-module m_illegaldecode (parameters LAZY_DECODE and MULDIV; inputs INSTR and corerunning; output illegal); m_illegaltrap holds the FSM, the registers and the counter.

Verification
REQ-035 Accept add 0x00B50533 -> 1 cycle later res_valid=1, res_legal=1, trap_req=0, instr_ready stays 1.
REQ-036 Accept 0x02B50533 (mul) with MULDIV=1 -> legal; with MULDIV=0 -> trap_req=1, mtval=0x02B50533.
REQ-037 Accept 0x00000000 -> trap_req=1, instr_ready=0 until trap_ack; instr_ready=1 on the cycle after ack; ill_cnt=1 if MIDGETV_ILLCNT_EN is defined.
REQ-038 Accept ecall with rd=1 (0x000000F3) -> illegal when LAZY_DECODE=0, legal when LAZY_DECODE=1.
REQ-039 With CNTW=2, trigger 5 illegal instructions -> ill_cnt=3; assert cnt_clr together with a 6th TRAP entry -> ill_cnt=0.
REQ-040 rst_n=0 while in TRAP -> next cycle trap_req=0, mtval=0, instr_ready=1; accept 0xFFFFFFFF with corerunning=0 -> res_legal=1, no trap.
